// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide DMem.
// Loads are extracted and extended into a registered result. Word stores go straight through.
// Sub-word stores take two cycles (read, then write the merged word) and stall the pipeline
// for the read cycle.
module mem_access_unit #(
   parameter int unsigned AW      = 5,
   parameter bit          BIG_END = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic [31:0]   Addr,
   input  logic [31:0]   WData,
   input  logic [1:0]    Size,
   input  logic          LdUnsigned,
   output logic [AW-1:0] DataAdr,
   output logic [31:0]   DataIn,
   output logic          DMemW,
   output logic          DMemR,
   input  logic [31:0]   DataOut,
   output logic [31:0]   LoadData,
   output logic          LoadValid,
   output logic          Stall,
   output logic          Err
);

   typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

   state_e        state_q, state_d;
   logic [31:0]   merge_q, merge_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [31:0]   load_data_q, load_data_d;
   logic          load_valid_q, load_valid_d;
   logic          err_q, err_d;

   logic          illegal;
   logic [2:0]    lane_bytes;
   logic [5:0]    be_shift;
   logic [4:0]    shamt;
   logic [31:0]   lane_mask;
   logic [31:0]   lane;
   logic [31:0]   load_ext;
   logic [31:0]   merged;

   // Address bits above the DMem word range wrap and are deliberately ignored.
   logic          unused_addr;
   assign unused_addr = ^Addr[31:AW+2];

   // Request legality; only meaningful while a request is present.
   always_comb begin
      illegal = (MemRead | MemWrite) &
                ((MemRead & MemWrite) ||
                 (Size == 2'b11) ||
                 (Size == 2'b01 && Addr[0]) ||
                 (Size == 2'b10 && Addr[1:0] != 2'b00));
   end

   // Bit position of the addressed lane within the word.
   always_comb begin
      lane_bytes = (Size == 2'b00) ? 3'd1 : (Size == 2'b01) ? 3'd2 : 3'd4;
      be_shift   = 6'd32 - {lane_bytes, 3'b000} - {1'b0, Addr[1:0], 3'b000};
      shamt      = BIG_END ? be_shift[4:0] : {Addr[1:0], 3'b000};
      lane_mask  = (Size == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
   end

   // Load extraction/extension and sub-word merge into the word read back from DMem.
   always_comb begin
      lane   = DataOut >> shamt;
      merged = (DataOut & ~(lane_mask << shamt)) | ((WData & lane_mask) << shamt);
      unique case (Size)
         2'b00:   load_ext = {{24{~LdUnsigned & lane[7]}}, lane[7:0]};
         2'b01:   load_ext = {{16{~LdUnsigned & lane[15]}}, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   // Next-state and DMem port control.
   always_comb begin
      state_d      = state_q;
      merge_d      = merge_q;
      adr_d        = adr_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      err_d        = 1'b0;
      DMemW        = 1'b0;
      DMemR        = 1'b0;
      Stall        = 1'b0;
      DataAdr      = Addr[AW+1:2];
      DataIn       = WData;
      unique case (state_q)
         StIdle: begin
            if (illegal) begin
               err_d = 1'b1;
            end else if (MemRead) begin
               DMemR        = 1'b1;
               load_data_d  = load_ext;
               load_valid_d = 1'b1;
            end else if (MemWrite) begin
               if (Size == 2'b10) begin
                  DMemW = 1'b1;
               end else begin
                  DMemR   = 1'b1;
                  Stall   = 1'b1;
                  merge_d = merged;
                  adr_d   = Addr[AW+1:2];
                  state_d = StRmwWr;
               end
            end
         end
         StRmwWr: begin
            // A reset landing here drops the pending write.
            DMemW   = ~rst;
            DataIn  = merge_q;
            DataAdr = adr_q;
            state_d = StIdle;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         merge_q      <= 32'h0;
         adr_q        <= '0;
         load_data_q  <= 32'h0;
         load_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         merge_q      <= merge_d;
         adr_q        <= adr_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         err_q        <= err_d;
      end
   end

   assign LoadData  = load_data_q;
   assign LoadValid = load_valid_q;
   assign Err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a byte-array reference memory.
module tb_mem_access_unit;

   localparam int unsigned AW     = 5;
   localparam int unsigned NWORDS = 1 << AW;
   localparam int unsigned NBYTES = 4 * NWORDS;

   logic          clk;
   logic          rst;
   logic          MemRead;
   logic          MemWrite;
   logic [31:0]   Addr;
   logic [31:0]   WData;
   logic [1:0]    Size;
   logic          LdUnsigned;
   logic [AW-1:0] DataAdr;
   logic [31:0]   DataIn;
   logic          DMemW;
   logic          DMemR;
   logic [31:0]   DataOut;
   logic [31:0]   LoadData;
   logic          LoadValid;
   logic          Stall;
   logic          Err;

   mem_access_unit #(
      .AW      (AW),
      .BIG_END (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Addr       (Addr),
      .WData      (WData),
      .Size       (Size),
      .LdUnsigned (LdUnsigned),
      .DataAdr    (DataAdr),
      .DataIn     (DataIn),
      .DMemW      (DMemW),
      .DMemR      (DMemR),
      .DataOut    (DataOut),
      .LoadData   (LoadData),
      .LoadValid  (LoadValid),
      .Stall      (Stall),
      .Err        (Err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DMem: read on negedge, write on posedge.
   logic [31:0] mem [NWORDS];
   always @(negedge clk) if (DMemR) DataOut <= mem[DataAdr];
   always @(posedge clk) if (DMemW) mem[DataAdr] <= DataIn;

   // Reference memory, byte addressed, little-endian.
   logic [7:0]  ref_bytes [NBYTES];
   logic [31:0] exp_load;
   int          n_checks;
   int          n_errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nbytes_of(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit is_illegal(input bit rd, input bit wr, input logic [31:0] a,
                                     input logic [1:0] sz);
      if (!rd && !wr) return 1'b0;
      return (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                            input bit uns);
      int          b;
      int          nb;
      logic [31:0] v;
      b  = int'(a[AW+1:0]);
      nb = nbytes_of(sz);
      v  = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[b+i]) << (8 * i));
      if (!uns && nb == 1 && v[7])  v = v | 32'hffff_ff00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hffff_0000;
      return v;
   endfunction

   function automatic logic [31:0] ref_word(input int widx);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < 4; i++) v = v | (32'(ref_bytes[4*widx+i]) << (8 * i));
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
      int b;
      b = int'(a[AW+1:0]);
      for (int i = 0; i < nbytes_of(sz); i++) ref_bytes[b+i] = wd[8*i +: 8];
   endtask

   // Issues one request starting at posedge+1 and checks it through completion.
   task automatic do_req(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input bit uns);
      bit          ill;
      logic [31:0] exp_adr;
      ill        = is_illegal(rd, wr, a, sz);
      exp_adr    = 32'(a[AW+1:2]);
      MemRead    = rd;
      MemWrite   = wr;
      Addr       = a;
      WData      = wd;
      Size       = sz;
      LdUnsigned = uns;
      #1;
      if (ill) begin
         check({tag, ".ill_dmemw"}, 32'(DMemW), 32'd0);
         check({tag, ".ill_dmemr"}, 32'(DMemR), 32'd0);
         check({tag, ".ill_stall"}, 32'(Stall), 32'd0);
      end else if (rd) begin
         check({tag, ".ld_dmemr"}, 32'(DMemR), 32'd1);
         check({tag, ".ld_dmemw"}, 32'(DMemW), 32'd0);
         check({tag, ".ld_adr"}, 32'(DataAdr), exp_adr);
         check({tag, ".ld_stall"}, 32'(Stall), 32'd0);
      end else if (wr && sz == 2'b10) begin
         check({tag, ".sw_dmemw"}, 32'(DMemW), 32'd1);
         check({tag, ".sw_dmemr"}, 32'(DMemR), 32'd0);
         check({tag, ".sw_adr"}, 32'(DataAdr), exp_adr);
         check({tag, ".sw_datain"}, DataIn, wd);
         check({tag, ".sw_stall"}, 32'(Stall), 32'd0);
         ref_store(a, wd, sz);
      end else if (wr) begin
         check({tag, ".rmw_rd_dmemr"}, 32'(DMemR), 32'd1);
         check({tag, ".rmw_rd_dmemw"}, 32'(DMemW), 32'd0);
         check({tag, ".rmw_rd_stall"}, 32'(Stall), 32'd1);
      end else begin
         check({tag, ".nop_en"}, 32'({DMemW, DMemR, Stall}), 32'd0);
      end
      @(posedge clk);
      #1;
      if (ill) begin
         check({tag, ".err"}, 32'(Err), 32'd1);
         check({tag, ".ill_lv"}, 32'(LoadValid), 32'd0);
         check({tag, ".ill_ld"}, LoadData, exp_load);
      end else if (rd) begin
         exp_load = ref_load(a, sz, uns);
         check({tag, ".lv"}, 32'(LoadValid), 32'd1);
         check({tag, ".ld"}, LoadData, exp_load);
         check({tag, ".ld_err"}, 32'(Err), 32'd0);
      end else if (wr && sz != 2'b10) begin
         ref_store(a, wd, sz);
         check({tag, ".rmw_wr_dmemw"}, 32'(DMemW), 32'd1);
         check({tag, ".rmw_wr_dmemr"}, 32'(DMemR), 32'd0);
         check({tag, ".rmw_wr_stall"}, 32'(Stall), 32'd0);
         check({tag, ".rmw_wr_adr"}, 32'(DataAdr), exp_adr);
         check({tag, ".rmw_wr_datain"}, DataIn, ref_word(int'(exp_adr)));
         @(posedge clk);
         #1;
      end else begin
         check({tag, ".idle_flags"}, 32'({LoadValid, Err}), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  sz;
      int          op;
      n_checks   = 0;
      n_errors   = 0;
      exp_load   = 32'h0;
      rst        = 1'b1;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Addr       = 32'h0;
      WData      = 32'h0;
      Size       = 2'b10;
      LdUnsigned = 1'b0;
      for (int i = 0; i < int'(NBYTES); i++) ref_bytes[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst.loaddata", LoadData, 32'h0);
      check("rst.flags", 32'({LoadValid, Err}), 32'd0);
      check("rst.enables", 32'({DMemW, DMemR, Stall}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int w = 0; w < int'(NWORDS); w++) do_req("fill", 0, 1, 32'(4 * w), $urandom, 2'b10, 0);

      do_req("tp_sw", 0, 1, 32'h0c, 32'hdead_beef, 2'b10, 0);
      do_req("tp_lw", 1, 0, 32'h0c, 32'h0, 2'b10, 0);
      check("tp_lw.const", LoadData, 32'hdead_beef);
      do_req("tp_sw2", 0, 1, 32'h0c, 32'h1122_3344, 2'b10, 0);
      do_req("tp_sb", 0, 1, 32'h0d, 32'h0000_00ab, 2'b00, 0);
      do_req("tp_lw2", 1, 0, 32'h0c, 32'h0, 2'b10, 0);
      check("tp_sb.word", LoadData, 32'h1122_ab44);
      do_req("tp_lb", 1, 0, 32'h0d, 32'h0, 2'b00, 0);
      check("tp_lb.const", LoadData, 32'hffff_ffab);
      do_req("tp_lbu", 1, 0, 32'h0d, 32'h0, 2'b00, 1);
      check("tp_lbu.const", LoadData, 32'h0000_00ab);
      do_req("tp_sh", 0, 1, 32'h0e, 32'h0000_8001, 2'b01, 0);
      do_req("tp_lw3", 1, 0, 32'h0c, 32'h0, 2'b10, 0);
      check("tp_sh.word", LoadData, 32'h8001_ab44);
      do_req("tp_lh", 1, 0, 32'h0e, 32'h0, 2'b01, 0);
      check("tp_lh.const", LoadData, 32'hffff_8001);
      do_req("tp_lhu", 1, 0, 32'h0e, 32'h0, 2'b01, 1);
      check("tp_lhu.const", LoadData, 32'h0000_8001);
      do_req("tp_mis_lw", 1, 0, 32'h0d, 32'h0, 2'b10, 0);
      do_req("tp_mis_sh", 0, 1, 32'h0f, 32'h1234, 2'b01, 0);
      do_req("tp_rdwr", 1, 1, 32'h0c, 32'h5555_5555, 2'b10, 0);
      do_req("tp_mis_chk", 1, 0, 32'h0c, 32'h0, 2'b10, 0);
      check("tp_mis.word", LoadData, 32'h8001_ab44);

      // Reset while the merged word is about to be written.
      MemRead  = 1'b0;
      MemWrite = 1'b1;
      Addr     = 32'h10;
      WData    = 32'h0000_00c3;
      Size     = 2'b00;
      #1;
      check("rstrmw.stall", 32'(Stall), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rstrmw.dmemw", 32'(DMemW), 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      MemWrite = 1'b0;
      exp_load = 32'h0;
      #1;
      check("rstrmw.loaddata", LoadData, 32'h0);
      check("rstrmw.idle", 32'({DMemW, DMemR, Stall}), 32'd0);
      @(posedge clk);
      #1;
      do_req("rstrmw_lw", 1, 0, 32'h10, 32'h0, 2'b10, 0);

      do_req("b2b_sb0", 0, 1, 32'h00, 32'h0000_005a, 2'b00, 0);
      do_req("b2b_sb1", 0, 1, 32'h01, 32'h0000_00a5, 2'b00, 0);
      do_req("b2b_lw", 1, 0, 32'h00, 32'h0, 2'b10, 0);
      check("b2b.low_half", 32'(LoadData[15:0]), 32'h0000_a55a);

      for (int n = 0; n < 400; n++) begin
         a  = $urandom;
         wd = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) < 3) begin
            if (sz == 2'b10) a[1:0] = 2'b00;
            if (sz == 2'b01) a[0] = 1'b0;
         end
         op = $urandom_range(0, 9);
         if (op == 0)      do_req("rnd_rdwr", 1, 1, a, wd, sz, $urandom_range(0, 1) == 1);
         else if (op <= 4) do_req("rnd_ld", 1, 0, a, wd, sz, $urandom_range(0, 1) == 1);
         else if (op <= 8) do_req("rnd_st", 0, 1, a, wd, sz, 0);
         else              do_req("rnd_nop", 0, 0, a, wd, sz, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit sitting directly upstream of the data memory (DMem). It takes EX/MEM load/store requests and drives the DMem word port (DataAdr/DataIn/DMemW/DMemR). Sub-word stores are done as a two-cycle read-modify-write with a pipeline stall. Loads are extracted, extended and registered as MEM/WB load data.

Parameters:
AW, 5, DMem word-address width (DataAdr width)
BIG_END, 0, byte lane order; 0 = little-endian (byte 0 in bits 7:0)

Ports:
clk  in  1  clock; DMem writes on posedge, reads on negedge of same clk
rst  in  1  synchronous active-high reset
MemRead  in  1  load request from EX/MEM
MemWrite  in  1  store request from EX/MEM
Addr  in  32  byte address from ALU
WData  in  32  store data (rt), low bytes used for sb/sh
Size  in  2  00 byte, 01 half, 10 word, 11 reserved
LdUnsigned  in  1  1 = zero-extend (lbu/lhu), 0 = sign-extend
DataAdr  out  AW  DMem word address = Addr[AW+1:2]
DataIn  out  32  DMem write data
DMemW  out  1  DMem write enable
DMemR  out  1  DMem read enable
DataOut  in  32  DMem read data, valid after negedge while DMemR=1
LoadData  out  32  registered extended load result
LoadValid  out  1  1-cycle pulse: LoadData updated
Stall  out  1  freeze PC/IF/ID/EX/MEM registers this cycle
Err  out  1  1-cycle pulse: misaligned/illegal request, memory untouched

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, LoadData=0, LoadValid=0, Err=0, merge register=0. DMemW, DMemR, Stall are combinational from state and are 0 while state=IDLE and no request is present.
- States: IDLE and RMW_WR.
- Illegal request, checked in IDLE only:
  - Any of: MemRead&MemWrite; Size=11; Size=01 with Addr[0]=1; Size=10 with Addr[1:0]!=0.
  - Response: DMemW=0, DMemR=0, Stall=0; Err=1 next cycle; LoadData unchanged; no LoadValid.
- Load (IDLE, MemRead, legal):
  - DMemR=1, DataAdr=Addr[AW+1:2].
  - At posedge: select the lane by Addr[1:0]/Size, extend per LdUnsigned, write LoadData, LoadValid=1 for one cycle.
  - Latency 1 cycle, no stall.
- Word store (IDLE, MemWrite, Size=10, legal):
  - DMemW=1, DataIn=WData, one cycle, no stall.
- Sub-word store (IDLE, MemWrite, Size=00/01, legal):
  - Cycle 1 (IDLE): DMemR=1, Stall=1. At posedge, capture DataOut with WData[7:0] or WData[15:0] merged into the lane selected by Addr[1:0]; also capture the word address; go to RMW_WR.
  - Cycle 2 (RMW_WR): DMemW=1, DataIn=merged word, DataAdr=captured address, Stall=0. Next state is IDLE.
  - Inputs are ignored in RMW_WR. The pipeline holds them stable because Stall was 1.
  - A new request is accepted only in the cycle after RMW_WR.
- No request in IDLE: all enables 0, Stall=0, state stays IDLE.
- Address bits above AW+1 are ignored; the address wraps modulo 2^AW words.
- Reset mid-RMW (rst=1 while in RMW_WR): DMemW is forced to 0 in that cycle, the write is dropped, and state returns to IDLE.
- Lane select (BIG_END=0):
  - Byte k = bits 8k+7:8k.
  - Half at Addr[1]=0 is bits 15:0; at Addr[1]=1 it is bits 31:16.
  - BIG_END=1 mirrors lanes: byte k -> bits 31-8k:24-8k.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x0C; next cycle lw @0x0C -> DataAdr=3, DMemW one cycle, LoadData=0xDEADBEEF with LoadValid one cycle later, Stall never 1.
- Byte RMW: mem[3]=0x11223344; sb WData=0xAB @0x0D -> Stall=1 for one cycle, then DMemW with DataIn=0x1122AB44; lb @0x0D -> 0xFFFFFFAB; lbu -> 0x000000AB.
- Halfword: sh WData=0x8001 @0x0E onto 0x1122AB44 -> 0x8001AB44; lh @0x0E -> 0xFFFF8001; lhu -> 0x00008001.
- Misaligned: lw @0x0D, sh @0x0F, and MemRead&MemWrite together -> Err pulses, DMemW=0, DMemR=0, LoadData unchanged.
- Reset mid-RMW: sb @0x10, assert rst in RMW_WR -> no DMemW, state=IDLE, LoadData=0; a lw @0x10 after reset returns the original word.
- Back-to-back: sb @0x00, then sb @0x01 held across the stall -> mem[0] ends with both bytes updated, with exactly one Stall cycle per store.
